// File: rtl/rpsc_interlock_bank.sv
// ============================================================================
//  Module      : rpsc_interlock_bank
//  Description : Parametrised interlock input bank. Each channel has a 2-FF
//                synchroniser, per-channel polarity, consecutive-cycle
//                debounce, optional hold-until-clear latching and a
//                registered LED annunciator drive with lamp test. The bank
//                also records the first fault (lowest index wins) and keeps
//                a saturating count of latched rising edges.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rpsc_interlock_bank #(
    parameter int              N_CH            = 16,
    parameter int              DEBOUNCE_CYCLES = 4,
    parameter int              CNT_W           = 8,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = '0,
    parameter logic [N_CH-1:0] LATCH_MASK      = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          i_raw,
    input  logic                     reset_hold_error,
    input  logic                     LA_TEST,
    output logic [N_CH-1:0]          o_fault_live,
    output logic [N_CH-1:0]          o_fault_latched,
    output logic [N_CH-1:0]          o_la,
    output logic                     o_any_fault,
    output logic                     o_first_valid,
    output logic [$clog2(N_CH)-1:0]  o_first_idx,
    output logic [CNT_W-1:0]         o_trip_count
);

    localparam int              c_IDX_W    = $clog2(N_CH);
    // Counter value on which a further mismatch flips the debounced state.
    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TRIP_MAX = '1;
    // Wide enough for the trip count plus up to 64 simultaneous rises.
    localparam int              c_SUM_W    = ((CNT_W > 7) ? CNT_W : 7) + 1;

    logic [N_CH-1:0]     r_sync1;
    logic [N_CH-1:0]     r_sync2;
    logic [N_CH-1:0]     r_live;
    logic [N_CH-1:0]     r_latched;
    logic [N_CH-1:0]     r_la;
    logic                r_first_valid;
    logic [c_IDX_W-1:0]  r_first_idx;
    logic [CNT_W-1:0]    r_trip_count;

    logic [N_CH-1:0]     w_fault;
    logic [N_CH-1:0]     w_live_nxt;
    logic [N_CH-1:0]     w_latched_nxt;
    logic [N_CH-1:0]     w_rise;
    logic [c_SUM_W-1:0]  w_rise_sum;
    logic [c_SUM_W-1:0]  w_trip_total;
    logic [CNT_W-1:0]    w_trip_nxt;
    logic [c_IDX_W-1:0]  w_low_idx;

    // Two-stage synchroniser; idles at the non-fault level of each channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= ACTIVE_LOW_MASK;
            r_sync2 <= ACTIVE_LOW_MASK;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity so that 1 always means fault downstream.
    assign w_fault = r_sync2 ^ ACTIVE_LOW_MASK;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic [CNT_W-1:0] r_db_cnt;
            logic             w_mismatch;
            logic             w_flip;

            assign w_mismatch    = w_fault[g] ^ r_live[g];
            assign w_flip        = w_mismatch && (r_db_cnt == c_DB_LAST);
            assign w_live_nxt[g] = r_live[g] ^ w_flip;

            // Count consecutive disagreeing cycles; any agreement restarts it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_db_cnt <= '0;
                end else if (!w_mismatch || w_flip) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            if (LATCH_MASK[g]) begin : g_hold
                // A fault present this edge always wins over the clear.
                assign w_latched_nxt[g] = w_live_nxt[g] |
                                          (r_latched[g] & ~reset_hold_error);
            end else begin : g_follow
                assign w_latched_nxt[g] = w_live_nxt[g];
            end
        end
    endgenerate

    assign w_rise = w_latched_nxt & ~r_latched;

    // Number of latched bits rising this edge, added to the saturating count.
    always_comb begin
        w_rise_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rise_sum = w_rise_sum + c_SUM_W'(w_rise[i]);
        end
        w_trip_total = c_SUM_W'(r_trip_count) + w_rise_sum;
        if (w_trip_total > c_SUM_W'(c_TRIP_MAX)) begin
            w_trip_nxt = c_TRIP_MAX;
        end else begin
            w_trip_nxt = w_trip_total[CNT_W-1:0];
        end
    end

    // Lowest set index of the registered latched vector.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_latched[i]) begin
                w_low_idx = c_IDX_W'(i);
            end
        end
    end

    // Debounced and held fault state update together on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live    <= '0;
            r_latched <= '0;
        end else begin
            r_live    <= w_live_nxt;
            r_latched <= w_latched_nxt;
        end
    end

    // Saturating trip counter; the clear takes priority over any increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trip_count <= '0;
        end else if (reset_hold_error) begin
            r_trip_count <= '0;
        end else begin
            r_trip_count <= w_trip_nxt;
        end
    end

    // First-fault record, frozen once captured until the hold clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else if (reset_hold_error) begin
            r_first_valid <= 1'b0;
        end else if (!r_first_valid && (|r_latched)) begin
            r_first_valid <= 1'b1;
            r_first_idx   <= w_low_idx;
        end
    end

    // Annunciator drive; lamp test lights everything without touching state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_la <= '0;
        end else if (LA_TEST) begin
            r_la <= '1;
        end else begin
            r_la <= r_latched;
        end
    end

    assign o_fault_live    = r_live;
    assign o_fault_latched = r_latched;
    assign o_la            = r_la;
    assign o_any_fault     = |r_latched;
    assign o_first_valid   = r_first_valid;
    assign o_first_idx     = r_first_idx;
    assign o_trip_count    = r_trip_count;

endmodule

`default_nettype wire
